depp_bus_ctrl: RTL and testbench
================================

Name: depp_bus_ctrl

Overview:
- Sequences host DEPP (parallel port EPP) cycles onto an internal 8-bit register bus with a req/ack handshake.
- Synchronises the asynchronous strobes and holds o_depp_wait until the register target completes.
- Optionally auto-increments the address after data cycles and guards against dead targets with a timeout.
- Sits between the top-level DEPP pins and the register bank or peripheral decoders.

Parameters:
- AUTO_INC, 1, 1 = increment the address register after every completed data cycle (wraps 0xFF->0x00); 0 = address static.
- TIMEOUT_CYCLES, 64, clocks to wait for i_reg_ack before forcing completion; range 2..255.
- TIMEOUT_DATA, 8'hFF, read data returned to the host on timeout.

Ports:
- i_clk_8mhz  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_depp_astb_n  in  1  address strobe, async, active-low
- i_depp_dstb_n  in  1  data strobe, async, active-low
- i_depp_write_n  in  1  0 = host write, 1 = host read
- i_depp_data  in  8  data from host pins
- o_depp_data  out  8  data to host pins
- o_depp_data_oe  out  1  pin output enable (top builds the tristate)
- o_depp_wait  out  1  EPP wait/ack to host
- o_reg_addr  out  8  current register address
- o_reg_wdata  out  8  write data
- o_reg_we  out  1  write request, one-clock pulse
- o_reg_re  out  1  read request, one-clock pulse
- i_reg_rdata  in  8  read data, valid with i_reg_ack
- i_reg_ack  in  1  target completion
- o_timeout_cnt  out  8  saturating count of timed-out cycles
- o_proto_err_cnt  out  8  saturating count of astb+dstb simultaneously low

Behaviour:
- Reset values: o_depp_wait=0, o_depp_data_oe=0, o_depp_data=0, o_reg_addr=0, o_reg_wdata=0, o_reg_we=0, o_reg_re=0, both counters=0, FSM=SYNC.
- Reset asserted mid-cycle aborts the cycle immediately. No request is issued and no counter changes in that cycle.
- Synchronisation: astb_n, dstb_n and write_n each pass through a 2-FF synchroniser (s_*). Host data is sampled directly; the host holds it stable while its strobe is low.
- Minimum latency: strobe falling edge to o_depp_wait high is 3 clocks for an address cycle and 4 clocks for a data cycle with same-cycle ack.
- SYNC: stay until s_astb_n=1 and s_dstb_n=1, then go to IDLE. This prevents acting on a strobe already low when reset releases.
- IDLE, both strobes low: increment o_proto_err_cnt, assert wait, go to HOLD. No register access.
- IDLE, astb low only, write: o_reg_addr<=i_depp_data; assert wait; go to HOLD.
- IDLE, astb low only, read: o_depp_data<=o_reg_addr; oe=1; assert wait; go to HOLD.
- IDLE, dstb low only, write: o_reg_wdata<=i_depp_data; pulse o_reg_we; go to ACK.
- IDLE, dstb low only, read: pulse o_reg_re; go to ACK.
- ACK: timer starts at 0 on entry.
  - On i_reg_ack for a read: o_depp_data<=i_reg_rdata, oe=1.
  - On i_reg_ack for either direction: assert wait, go to HOLD.
  - An ack in the same cycle as the we/re pulse is also valid; it completes on the first ACK cycle.
  - No ack by timer=TIMEOUT_CYCLES-1: read returns TIMEOUT_DATA with oe=1; increment o_timeout_cnt; assert wait; go to HOLD.
- HOLD: when s_astb_n=1 and s_dstb_n=1:
  - deassert wait and oe;
  - if the cycle was a data cycle (completed or timed out) and AUTO_INC=1, o_reg_addr<=o_reg_addr+1 (mod 256);
  - go to IDLE.
- i_reg_ack outside ACK is ignored.
- o_reg_we and o_reg_re are never high together and are never high for more than 1 clock per cycle.
- Counters saturate at 0xFF.
- o_reg_addr changes only on an address write, auto-increment, or reset.

Test Plan:
- Address write 0x3C, then address read -> o_reg_addr=0x3C, read returns 0x3C, wait rises 3 clocks after astb fall and falls 2-3 clocks after astb rise.
- Address 0x10, data write 0xA5, target acks after 5 clocks -> single o_reg_we pulse with addr 0x10/wdata 0xA5; wait stays low until the ack; o_reg_addr=0x11 afterwards (AUTO_INC=1).
- Address 0xFF, data read, target returns 0x5A with same-cycle ack -> host reads 0x5A, oe only during HOLD, address wraps to 0x00.
- Data read with no ack -> wait rises after TIMEOUT_CYCLES, host reads 0xFF, o_timeout_cnt=1; 256 timeouts -> counter holds at 0xFF.
- Both strobes low together -> no we/re pulse, o_proto_err_cnt=1, wait high until both strobes high.
- Reset pulsed during ACK with dstb still low -> outputs return to reset values, no transaction until dstb goes high and then falls again; the next cycle runs normally.

Source files
------------

// File: rtl/depp_bus_ctrl.sv
// DEPP (EPP parallel port) host cycle sequencer onto an 8-bit register bus
// with req/ack handshake, optional address auto-increment and ack timeout.
module depp_bus_ctrl #(
  parameter bit          AUTO_INC       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
  input  logic       i_clk_8mhz,
  input  logic       i_rst,
  input  logic       i_depp_astb_n,
  input  logic       i_depp_dstb_n,
  input  logic       i_depp_write_n,
  input  logic [7:0] i_depp_data,
  output logic [7:0] o_depp_data,
  output logic       o_depp_data_oe,
  output logic       o_depp_wait,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  output logic       o_reg_re,
  input  logic [7:0] i_reg_rdata,
  input  logic       i_reg_ack,
  output logic [7:0] o_timeout_cnt,
  output logic [7:0] o_proto_err_cnt
);

  typedef enum logic [1:0] {SYNC, IDLE, ACK, HOLD} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  logic   astb_meta, dstb_meta, write_meta;
  logic   s_astb_n, s_dstb_n, s_write_n;
  state_t state, state_next;
  logic [7:0] timer, timer_next;
  logic   data_cycle, data_cycle_next;
  logic   is_read, is_read_next;
  logic [7:0] depp_data_next, reg_addr_next, reg_wdata_next;
  logic [7:0] timeout_cnt_next, proto_err_cnt_next;
  logic   data_oe_next, wait_next, reg_we_next, reg_re_next;

  // Strobe synchronisers reset to the asserted level so SYNC only leaves once
  // the host has genuinely released both strobes after reset.
  always_ff @(posedge i_clk_8mhz) begin
    if (i_rst) begin
      {astb_meta, dstb_meta, write_meta} <= 3'b000;
      {s_astb_n, s_dstb_n, s_write_n}    <= 3'b000;
    end else begin
      {astb_meta, dstb_meta, write_meta} <= {i_depp_astb_n, i_depp_dstb_n, i_depp_write_n};
      {s_astb_n, s_dstb_n, s_write_n}    <= {astb_meta, dstb_meta, write_meta};
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk_8mhz) begin
    if (i_rst) begin
      state           <= SYNC;
      timer           <= 8'd0;
      data_cycle      <= 1'b0;
      is_read         <= 1'b0;
      o_depp_data     <= 8'd0;
      o_depp_data_oe  <= 1'b0;
      o_depp_wait     <= 1'b0;
      o_reg_addr      <= 8'd0;
      o_reg_wdata     <= 8'd0;
      o_reg_we        <= 1'b0;
      o_reg_re        <= 1'b0;
      o_timeout_cnt   <= 8'd0;
      o_proto_err_cnt <= 8'd0;
    end else begin
      state           <= state_next;
      timer           <= timer_next;
      data_cycle      <= data_cycle_next;
      is_read         <= is_read_next;
      o_depp_data     <= depp_data_next;
      o_depp_data_oe  <= data_oe_next;
      o_depp_wait     <= wait_next;
      o_reg_addr      <= reg_addr_next;
      o_reg_wdata     <= reg_wdata_next;
      o_reg_we        <= reg_we_next;
      o_reg_re        <= reg_re_next;
      o_timeout_cnt   <= timeout_cnt_next;
      o_proto_err_cnt <= proto_err_cnt_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next         = state;
    timer_next         = timer;
    data_cycle_next    = data_cycle;
    is_read_next       = is_read;
    depp_data_next     = o_depp_data;
    data_oe_next       = o_depp_data_oe;
    wait_next          = o_depp_wait;
    reg_addr_next      = o_reg_addr;
    reg_wdata_next     = o_reg_wdata;
    reg_we_next        = 1'b0;
    reg_re_next        = 1'b0;
    timeout_cnt_next   = o_timeout_cnt;
    proto_err_cnt_next = o_proto_err_cnt;
    case (state)
      SYNC: begin
        if (s_astb_n && s_dstb_n) begin
          state_next = IDLE;
        end else begin
          state_next = SYNC;
        end
      end
      IDLE: begin
        if (!s_astb_n && !s_dstb_n) begin
          proto_err_cnt_next = sat_inc(o_proto_err_cnt);
          data_cycle_next    = 1'b0;
          wait_next          = 1'b1;
          state_next         = HOLD;
        end else if (!s_astb_n) begin
          data_cycle_next = 1'b0;
          if (!s_write_n) begin
            reg_addr_next = i_depp_data;
          end else begin
            depp_data_next = o_reg_addr;
            data_oe_next   = 1'b1;
          end
          wait_next  = 1'b1;
          state_next = HOLD;
        end else if (!s_dstb_n) begin
          data_cycle_next = 1'b1;
          is_read_next    = s_write_n;
          timer_next      = 8'd0;
          if (!s_write_n) begin
            reg_wdata_next = i_depp_data;
            reg_we_next    = 1'b1;
          end else begin
            reg_re_next = 1'b1;
          end
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      ACK: begin
        if (i_reg_ack) begin
          if (is_read) begin
            depp_data_next = i_reg_rdata;
            data_oe_next   = 1'b1;
          end else begin
            data_oe_next = 1'b0;
          end
          wait_next  = 1'b1;
          state_next = HOLD;
        end else if (timer == TIMER_LAST) begin
          if (is_read) begin
            depp_data_next = TIMEOUT_DATA;
            data_oe_next   = 1'b1;
          end else begin
            data_oe_next = 1'b0;
          end
          timeout_cnt_next = sat_inc(o_timeout_cnt);
          wait_next        = 1'b1;
          state_next       = HOLD;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      HOLD: begin
        if (s_astb_n && s_dstb_n) begin
          wait_next    = 1'b0;
          data_oe_next = 1'b0;
          if (data_cycle && AUTO_INC) begin
            reg_addr_next = o_reg_addr + 8'd1;
          end else begin
            reg_addr_next = o_reg_addr;
          end
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = SYNC;
      end
    endcase
  end

endmodule

// File: tb/tb_depp_bus_ctrl.sv
// Scoreboard bench for depp_bus_ctrl: host tasks queue expected bus/wait
// events, a monitor pops and compares them as the DUT presents them.
module tb_depp_bus_ctrl;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       astb_n, dstb_n, write_n;
  logic [7:0] depp_in;
  logic [7:0] depp_out;
  logic       depp_oe, depp_wait;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, reg_ack;
  logic [7:0] timeout_cnt, proto_err_cnt;

  always #5 clk = ~clk;

  depp_bus_ctrl dut (
    .i_clk_8mhz(clk), .i_rst(i_rst),
    .i_depp_astb_n(astb_n), .i_depp_dstb_n(dstb_n), .i_depp_write_n(write_n),
    .i_depp_data(depp_in), .o_depp_data(depp_out), .o_depp_data_oe(depp_oe),
    .o_depp_wait(depp_wait), .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata),
    .o_reg_we(reg_we), .o_reg_re(reg_re), .i_reg_rdata(reg_rdata), .i_reg_ack(reg_ack),
    .o_timeout_cnt(timeout_cnt), .o_proto_err_cnt(proto_err_cnt)
  );

  localparam int K_WE = 0, K_RE = 1, K_WAIT = 2;
  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    bit         chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic wait_prev = 1'b0;

  bit         tgt_respond = 1'b1;
  int         tgt_delay   = 0;
  int         tgt_left    = -1;
  logic [7:0] tgt_rdata   = 8'h00;
  logic [7:0] exp_addr    = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d, input bit cd);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  // Register target model: acks tgt_delay clocks after a we/re pulse.
  always @(negedge clk) begin
    reg_ack = 1'b0;
    if (tgt_left == 0) begin
      reg_ack = 1'b1; reg_rdata = tgt_rdata; tgt_left = -1;
    end else if (tgt_left > 0) begin
      tgt_left = tgt_left - 1;
    end
    if ((reg_we || reg_re) && tgt_respond) begin
      if (tgt_delay == 0) begin
        reg_ack = 1'b1; reg_rdata = tgt_rdata;
      end else begin
        tgt_left = tgt_delay - 1;
      end
    end
  end

  // Monitor: pops an expectation for every bus pulse and every wait rise.
  always @(negedge clk) begin
    if (i_rst) begin
      wait_prev = 1'b0;
    end else begin
      if (reg_we || reg_re) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL bus_unexpected: we=%0b re=%0b addr=0x%0h with no expectation", reg_we, reg_re, reg_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_kind", reg_re ? K_RE : K_WE, mon_e.kind);
          chk("we_re_exclusive", reg_we & reg_re, 0);
          chk("bus_addr", reg_addr, mon_e.addr);
          if (reg_we) chk("bus_wdata", reg_wdata, mon_e.data);
        end
      end
      if (depp_wait && !wait_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wait_unexpected: wait rose with no expectation");
        end else begin
          mon_e = exp_q.pop_front();
          chk("wait_kind", K_WAIT, mon_e.kind);
          chk("wait_oe", depp_oe, mon_e.chk_data);
          if (mon_e.chk_data) chk("host_rdata", depp_out, mon_e.data);
        end
      end
      wait_prev = depp_wait;
    end
  end

  task automatic wait_for(input logic lvl, input int bound, output int n);
    n = 0;
    while (depp_wait !== lvl && n < bound) begin
      @(negedge clk); n++;
    end
    if (depp_wait !== lvl) begin
      n_checks++; n_fail++;
      $display("FAIL wait_bound: wait did not reach %0b within %0d clocks", lvl, bound);
    end
  endtask

  // One complete host cycle; returns strobe-to-wait latencies and early-oe flag.
  task automatic host_cycle(input bit is_addr, input bit is_write, input logic [7:0] d,
                            output int lat_rise, output int lat_fall, output bit early_oe);
    write_n = ~is_write; depp_in = d;
    @(negedge clk);
    if (is_addr) astb_n = 1'b0; else dstb_n = 1'b0;
    lat_rise = 0; early_oe = 1'b0;
    while (!depp_wait && lat_rise < 400) begin
      @(negedge clk); lat_rise++;
      if (!depp_wait && depp_oe) early_oe = 1'b1;
    end
    if (!depp_wait) begin
      n_checks++; n_fail++;
      $display("FAIL wait_rise_bound: no wait after %0d clocks", lat_rise);
    end
    astb_n = 1'b1; dstb_n = 1'b1;
    wait_for(1'b0, 20, lat_fall);
    @(negedge clk);
    write_n = 1'b1; depp_in = 8'h00;
  endtask

  initial begin
    int lr, lf, n;
    bit eo;
    i_rst = 1'b1; astb_n = 1'b1; dstb_n = 1'b1; write_n = 1'b1;
    depp_in = 8'h00; reg_rdata = 8'h00; reg_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_regs", {depp_out, reg_addr, reg_wdata, timeout_cnt}, 32'h0);
    chk("rst_ctrl", {depp_wait, depp_oe, reg_we, reg_re, proto_err_cnt}, 32'h0);
    i_rst = 1'b0;
    repeat (5) @(negedge clk);

    // Address write then address read.
    push(K_WAIT, 8'h00, 8'h00, 1'b0);
    host_cycle(1'b1, 1'b1, 8'h3C, lr, lf, eo);
    exp_addr = 8'h3C;
    chk("addr_wr_lat", lr, 3);
    chk("addr_wr_fall_2to3", (lf >= 2 && lf <= 3), 1);
    chk("addr_reg_3c", reg_addr, 8'h3C);
    push(K_WAIT, 8'h00, 8'h3C, 1'b1);
    host_cycle(1'b1, 1'b0, 8'h00, lr, lf, eo);
    chk("addr_rd_lat", lr, 3);

    // Data write with ack 5 clocks after the we pulse.
    push(K_WAIT, 8'h00, 8'h00, 1'b0);
    host_cycle(1'b1, 1'b1, 8'h10, lr, lf, eo);
    tgt_delay = 5;
    push(K_WE, 8'h10, 8'hA5, 1'b0);
    push(K_WAIT, 8'h00, 8'h00, 1'b0);
    host_cycle(1'b0, 1'b1, 8'hA5, lr, lf, eo);
    chk("dwr_slow_ack_lat", lr, 9);
    chk("autoinc_11", reg_addr, 8'h11);

    // Data read at 0xFF with same-cycle ack; address wraps.
    push(K_WAIT, 8'h00, 8'h00, 1'b0);
    host_cycle(1'b1, 1'b1, 8'hFF, lr, lf, eo);
    tgt_delay = 0; tgt_rdata = 8'h5A;
    push(K_RE, 8'hFF, 8'h00, 1'b0);
    push(K_WAIT, 8'h00, 8'h5A, 1'b1);
    host_cycle(1'b0, 1'b0, 8'h00, lr, lf, eo);
    chk("drd_fast_lat", lr, 4);
    chk("oe_before_hold", eo, 1'b0);
    chk("oe_after_hold", depp_oe, 1'b0);
    chk("addr_wrap_00", reg_addr, 8'h00);
    exp_addr = 8'h00;

    // Timeouts and counter saturation.
    tgt_respond = 1'b0;
    push(K_RE, exp_addr, 8'h00, 1'b0);
    push(K_WAIT, 8'h00, 8'hFF, 1'b1);
    host_cycle(1'b0, 1'b0, 8'h00, lr, lf, eo);
    exp_addr = exp_addr + 8'd1;
    chk("timeout_lat", lr, 67);
    chk("timeout_cnt_1", timeout_cnt, 8'd1);
    for (int i = 0; i < 256; i++) begin
      push(K_RE, exp_addr, 8'h00, 1'b0);
      push(K_WAIT, 8'h00, 8'hFF, 1'b1);
      host_cycle(1'b0, 1'b0, 8'h00, lr, lf, eo);
      exp_addr = exp_addr + 8'd1;
      if (i == 254) chk("timeout_cnt_255", timeout_cnt, 8'hFF);
    end
    chk("timeout_cnt_sat", timeout_cnt, 8'hFF);
    chk("addr_after_timeouts", reg_addr, exp_addr);

    // Both strobes low together.
    push(K_WAIT, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    astb_n = 1'b0; dstb_n = 1'b0;
    wait_for(1'b1, 20, n);
    chk("proto_lat", n, 3);
    chk("proto_cnt_1", proto_err_cnt, 8'd1);
    astb_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("proto_wait_held", depp_wait, 1'b1);
    dstb_n = 1'b1;
    wait_for(1'b0, 20, n);
    chk("proto_addr_kept", reg_addr, exp_addr);

    // Reset while in ACK with dstb still low.
    push(K_RE, exp_addr, 8'h00, 1'b0);
    write_n = 1'b1;
    @(negedge clk);
    dstb_n = 1'b0;
    n = 0;
    while (!reg_re && n < 10) begin @(negedge clk); n++; end
    chk("rst_test_re_seen", reg_re, 1'b1);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("midrst_data_regs", {depp_out, reg_addr, reg_wdata, timeout_cnt}, 32'h0);
    chk("midrst_ctrl", {depp_wait, depp_oe, reg_we, reg_re, proto_err_cnt}, 32'h0);
    @(negedge clk);
    i_rst = 1'b0;
    exp_addr = 8'h00;
    chk("midrst_queue_empty", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    chk("midrst_no_wait", depp_wait, 1'b0);
    dstb_n = 1'b1;
    repeat (4) @(negedge clk);
    tgt_respond = 1'b1; tgt_delay = 1;
    push(K_WE, 8'h00, 8'h77, 1'b0);
    push(K_WAIT, 8'h00, 8'h00, 1'b0);
    host_cycle(1'b0, 1'b1, 8'h77, lr, lf, eo);
    chk("post_rst_lat", lr, 5);
    chk("post_rst_addr", reg_addr, 8'h01);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
